mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_pkg.sv | 27 ++
 rtl/mul_pp_column_gen.sv | 44 ++++
 rtl/mul_sequencer.sv | 104 ++++++++++
 tb/tb_mul_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the column-compressor multiplier sequencer.
// Holds the default operand width, the column count, the per-column height
// and first-index functions (also used by the shift-register and compressor
// generators), and the sequencer state encoding.
package mul_pkg;

  localparam int MUL_N    = 30;
  localparam int MUL_COLS = 2 * MUL_N - 1;

  // Number of partial-product bits that land in column k.
  function automatic int h_k(input int k, input int n);
    return ((k + 1) < (2 * n - 1 - k)) ? (k + 1) : (2 * n - 1 - k);
  endfunction

  // Lowest a-operand index contributing to column k.
  function automatic int i_min(input int k, input int n);
    return (k > n - 1) ? (k - n + 1) : 0;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mul_pp_column_gen.sv
// Partial-product serializer: for load step t, drives one AND-term per
// compressor column onto that column's serial shift input.
// Ports:
//   i_a, i_b     registered operands
//   i_t          load step counter (0..N-1)
//   i_load_en    high only while the sequencer is loading
//   o_col_bit    bit k feeds the serial input of column k
// Short columns stay at 0 for the first N-h_k steps so every column still
// sees exactly N shifts; this flushes leftovers from the previous product.
module mul_pp_column_gen
  import mul_pkg::*;
#(
  parameter int N  = MUL_N,
  parameter int TW = $clog2(MUL_N + 1)
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic [TW-1:0]  i_t,
  input  logic           i_load_en,
  output logic [2*N-2:0] o_col_bit
);

  localparam int PW = 1 << TW;

  for (genvar k = 0; k < 2 * N - 1; k++) begin : g_col
    localparam int H  = h_k(k, N);
    localparam int IM = i_min(k, N);
    localparam logic [TW-1:0] OFF = TW'(N - H);

    logic [H-1:0]  w_pp;
    logic [PW-1:0] w_pp_ext;
    logic [TW-1:0] w_sel;

    // Term j of this column is a[IM+j] & b[k-IM-j], emitted at step OFF+j.
    for (genvar j = 0; j < H; j++) begin : g_term
      assign w_pp[j] = i_a[IM+j] & i_b[k-IM-j];
    end

    assign w_pp_ext     = {{(PW - H){1'b0}}, w_pp};
    assign w_sel        = i_t - OFF;
    assign o_col_bit[k] = i_load_en & (i_t >= OFF) & w_pp_ext[w_sel];
  end

endmodule

// File: rtl/mul_sequencer.sv
// Sequencer for a shift-register/compressor multiplier. Accepts an operand
// pair, streams partial products into the external column shift registers
// for N cycles, captures the compressed sum, and holds it until consumed.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b   operand handshake (ready only in IDLE)
//   col_bit                  serial inputs of the 2N-1 column shift registers
//   col_dst                  compressor result (2N bits)
//   out_valid/out_ready/out_product   product handshake
//   busy                     high whenever not IDLE
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [2*N-2:0] col_bit,
  input  logic [2*N-1:0] col_dst,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_product,
  output logic           busy
);

  localparam int TW = $clog2(N + 1);
  localparam logic [TW-1:0] LAST_T = TW'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_t;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_product;
  logic           w_load_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_t       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
            r_t <= '0;
          end
        end
        S_LOAD:    r_t <= (r_t == LAST_T) ? '0 : r_t + TW'(1);
        S_CAPTURE: r_product <= col_dst;
        default:   ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    w_load_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load_en = 1'b1;
        if (r_t == LAST_T) w_next = S_CAPTURE;
      end
      // Shift registers settled on the last LOAD edge; sample them once.
      S_CAPTURE: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  mul_pp_column_gen #(
    .N  (N),
    .TW (TW)
  ) u_pp_gen (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_t       (r_t),
    .i_load_en (w_load_en),
    .o_col_bit (col_bit)
  );

  assign out_product = r_product;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  localparam int N    = 30;
  localparam int W    = 2 * N;
  localparam int NCOL = 2 * N - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;
  logic [NCOL-1:0] col_bit;
  logic [W-1:0]    col_dst;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_product;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .col_bit     (col_bit),
    .col_dst     (col_dst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  // Environment: one N-deep shift register per column plus an ideal
  // compressor that sums each column's ones weighted by 2^k.
  logic [N-1:0] sr [NCOL];

  always @(posedge clk) begin
    for (int k = 0; k < NCOL; k++) sr[k] <= {sr[k][N-2:0], col_bit[k]};
  end

  always_comb begin
    col_dst = '0;
    for (int k = 0; k < NCOL; k++) col_dst = col_dst + (W'($countones(sr[k])) << k);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation: offer, measure latency from the accept cycle,
  // optionally stall the consumer, then accept the product.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [63:0] exp, input int hold,
                        output logic [NCOL-1:0] col_last);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    col_last  = '0;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      if (lat == N) col_last = col_bit;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(N + 2));
    chk({tag, " product"}, 64'(out_product), exp);
    chk({tag, " col_bit done"}, 64'(col_bit), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold product"}, 64'(out_product), exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid dropped"}, 64'(out_valid), 64'd0);
    chk({tag, " back idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCOL-1:0] cl;
    int nv, acc, dn, bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset product", 64'(out_product), 64'd0);
    chk("reset col_bit", 64'(col_bit), 64'd0);

    // out_ready while nothing is pending does nothing
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle out_ready valid", 64'(out_valid), 64'd0);
    chk("idle out_ready busy", 64'(busy), 64'd0);
    out_ready = 1'b0;

    run_op("1x1", 30'd1, 30'd1, 64'h1, 0, cl);
    chk("1x1 col_bit last step", 64'(cl), 64'h1);

    run_op("max*max", 30'h3FFFFFFF, 30'h3FFFFFFF, 64'h0FFFFFFF80000001, 0, cl);
    chk("max*max col_bit last step", 64'(cl), 64'h07FFFFFFFFFFFFFF);

    run_op("stall", 30'h2AAAAAAA, 30'h15555555, 64'h038E38E371C71C72, 10, cl);

    run_op("b2b 7x9", 30'd7, 30'd9, 64'd63, 0, cl);
    run_op("b2b max*0", 30'h3FFFFFFF, 30'd0, 64'd0, 0, cl);

    // Abort during LOAD at t=15
    @(negedge clk);
    in_a = 30'h3FFFFFFF; in_b = 30'h3FFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort product", 64'(out_product), 64'd0);
    chk("abort col_bit", 64'(col_bit), 64'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("abort no out_valid", 64'(nv), 64'd0);
    run_op("after abort 3x5", 30'd3, 30'd5, 64'd15, 0, cl);

    // Abort in DONE with out_ready asserted on the same edge
    @(negedge clk);
    in_a = 30'd7; in_b = 30'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nv = 0;
    while (!out_valid && nv < 100) begin
      @(negedge clk);
      nv++;
    end
    chk("done-abort reached done", 64'(out_valid), 64'd1);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    chk("done-abort valid", 64'(out_valid), 64'd0);
    chk("done-abort product", 64'(out_product), 64'd0);

    // rst wins over an offered operand in IDLE
    in_a = 30'd2; in_b = 30'd2; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst vs in_valid busy", 64'(busy), 64'd0);

    // in_valid held high: one operation per IDLE visit, ready low while busy
    @(negedge clk);
    in_a = 30'd2; in_b = 30'd3; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; dn = 0; bad = 0;
    for (int i = 0; i < 3 * (N + 3); i++) begin
      if (in_valid && in_ready) acc++;
      if (busy && in_ready) bad++;
      if (out_valid) begin
        dn++;
        if (out_product !== W'(6)) bad++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("held accepts", 64'(acc), 64'd3);
    chk("held completions", 64'(dn), 64'd3);
    chk("held violations", 64'(bad), 64'd0);
    chk("held final idle", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
